// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the instruction cache.
//   ICACHE_SETS    : default number of direct-mapped frames
//   ICACHE_IDX_W   : index width derived from ICACHE_SETS
//   ICACHE_TAG_W   : tag width, address[31:2+IDX_W]
//   word_t         : 32-bit machine word
//   icachef_t      : fetch address split {tag, idx, bytoff} at the default size
//   icache_state_t : cache controller states {IDLE, FETCH}
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the datapath fetch port, the flush request and the memory
// controller instruction port of the instruction cache.
//   slave  : the cache's view (takes fetch requests, issues memory reads)
//   master : the environment's view (datapath + memory controller)
// Handshake: dp_imemREN is a level request; the cache answers with dp_ihit in
// the same cycle on a hit. Toward memory, iREN/iaddr are held steady until a
// cycle where iwait is low, and iload is valid in exactly that cycle.
// Optional macro ICACHE_STATS_EN adds hit_count / miss_count.
// -----------------------------------------------------------------------------
import icache_pkg::*;

interface icache_if;
  logic  dp_imemREN;
  word_t dp_imemaddr;
  logic  dp_ihit;
  word_t dp_imemload;
  logic  flush;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  dp_imemREN, dp_imemaddr, flush, iwait, iload,
    output dp_ihit, dp_imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output dp_imemREN, dp_imemaddr, flush, iwait, iload,
    input  dp_ihit, dp_imemload, iREN, iaddr, hit_count, miss_count
  );
`else
  modport slave (
    input  dp_imemREN, dp_imemaddr, flush, iwait, iload,
    output dp_ihit, dp_imemload, iREN, iaddr
  );
  modport master (
    output dp_imemREN, dp_imemaddr, flush, iwait, iload,
    input  dp_ihit, dp_imemload, iREN, iaddr
  );
`endif
endinterface

// File: rtl/icache_frame_array.sv
// -----------------------------------------------------------------------------
// icache_frame_array
// Valid/tag/data storage for a direct-mapped cache.
//   i_clk, i_rst_n : clock, async active-low reset (clears valid bits only)
//   i_flush        : invalidate every frame at the clock edge
//   i_ridx         : combinational read index -> o_rvalid/o_rtag/o_rdata
//   i_we, i_widx, i_wtag, i_wdata : single write port, marks frame valid
// A write in the same cycle as a flush leaves the written frame valid.
// -----------------------------------------------------------------------------
import icache_pkg::*;

module icache_frame_array #(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_ridx,
  output logic             o_rvalid,
  output logic [TAG_W-1:0] o_rtag,
  output word_t            o_rdata,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [TAG_W-1:0] i_wtag,
  input  word_t            i_wdata
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  word_t            r_data [SETS];

  // Later assignment wins: a fill overrides a same-cycle flush for its frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_flush) r_valid <= '0;
      if (i_we)    r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_rvalid = r_valid[i_ridx];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-block, read-only instruction cache.
//   CLK, nRST   : clock (rising edge), asynchronous active-low reset
//   bus         : icache_if.slave -- fetch port, flush, memory read port
//   o_dbg_state : current controller state (IDLE / FETCH)
// Hits are served combinationally in IDLE. A miss latches the word address,
// moves to FETCH and holds iREN/iaddr until iwait drops; the fill is written
// to the frame of the latched address regardless of what the datapath does
// meanwhile, and the following IDLE cycle hits if the address is unchanged.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters on bus.
// -----------------------------------------------------------------------------
import icache_pkg::*;

module icache #(
  parameter int SETS = ICACHE_SETS
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_if.slave       bus,
  output icache_state_t o_dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    r_state;
  word_t            r_miss_addr;
  logic             r_iren;

  logic [IDX_W-1:0] w_req_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_rvalid;
  logic [TAG_W-1:0] w_rtag;
  word_t            w_rdata;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;

  assign w_req_idx = bus.dp_imemaddr[1+IDX_W:2];
  assign w_req_tag = bus.dp_imemaddr[31:2+IDX_W];

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_flush  (bus.flush),
    .i_ridx   (w_req_idx),
    .o_rvalid (w_rvalid),
    .o_rtag   (w_rtag),
    .o_rdata  (w_rdata),
    .i_we     (w_fill),
    .i_widx   (r_miss_addr[1+IDX_W:2]),
    .i_wtag   (r_miss_addr[31:2+IDX_W]),
    .i_wdata  (bus.iload)
  );

  // A flush this cycle suppresses the hit, so the request becomes a miss.
  assign w_hit  = (r_state == IDLE) && bus.dp_imemREN && w_rvalid &&
                  (w_rtag == w_req_tag) && !bus.flush;
  assign w_miss = (r_state == IDLE) && bus.dp_imemREN && !w_hit;
  assign w_fill = (r_state == FETCH) && !bus.iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      r_iren      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_addr <= {bus.dp_imemaddr[31:2], 2'b00};
            r_iren      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.iwait) begin
            r_iren  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_iren  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dp_ihit     = w_hit;
  assign bus.dp_imemload = w_hit ? w_rdata : '0;
  assign bus.iREN        = r_iren;
  assign bus.iaddr       = r_miss_addr;
  assign o_dbg_state     = r_state;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Counters saturate and survive flush; only nRST clears them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Self-checking bench for icache. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge. A reference model keeps, per set,
// the cached word address and data, plus a word-addressed memory image.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
import icache_pkg::*;

module tb_icache;

  localparam int SETS = ICACHE_SETS;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  icache_if      bus();
  icache_state_t dbg_state;

  icache #(.SETS(SETS)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  bit    m_valid [SETS];
  word_t m_addr  [SETS];
  word_t m_data  [SETS];
  word_t mem     [word_t];
  longint m_hits;
  longint m_misses;

  int n_checks = 0;
  int n_errors = 0;

  task automatic get_mem(input word_t wa, output word_t d);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    d = mem[wa];
  endtask

  task automatic model_clear_valid();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver: one complete read ----------------
  // Drives a request, checks hit or the full miss/fill/refill-hit sequence.
  task automatic do_read(input word_t addr, input int waits,
                         input bit fl_detect, input bit fl_fill);
    word_t wa;
    word_t d;
    int    idx;
    bit    exp_hit;
    wa  = {addr[31:2], 2'b00};
    idx = int'((wa >> 2) % SETS);
    get_mem(wa, d);
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = addr;
    bus.flush       = fl_detect;
    bus.iwait       = 1'b1;
    exp_hit = !fl_detect && m_valid[idx] && (m_addr[idx] == wa);
    @(negedge CLK);
    n_checks++;
    if (bus.dp_ihit !== exp_hit) begin
      n_errors++;
      $display("FAIL lookup_ihit addr=%h got=%b want=%b", addr, bus.dp_ihit, exp_hit);
    end
    n_checks++;
    if (bus.dp_imemload !== (exp_hit ? d : 32'h0)) begin
      n_errors++;
      $display("FAIL lookup_data addr=%h got=%h want=%h", addr, bus.dp_imemload,
               exp_hit ? d : 32'h0);
    end
    n_checks++;
    if (bus.iREN !== 1'b0) begin
      n_errors++;
      $display("FAIL lookup_iren addr=%h got=%b want=0", addr, bus.iREN);
    end
    if (exp_hit) m_hits++; else m_misses++;
    if (fl_detect) model_clear_valid();
    step();
    bus.flush = 1'b0;
    if (!exp_hit) begin
      for (int k = 0; k <= waits; k++) begin
        bus.iwait = (k < waits);
        bus.iload = (k < waits) ? $urandom : d;
        bus.flush = fl_fill && (k == waits);
        @(negedge CLK);
        n_checks++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== wa || bus.dp_ihit !== 1'b0) begin
          n_errors++;
          $display("FAIL fetch_port cyc=%0d iren=%b iaddr=%h ihit=%b want 1/%h/0",
                   k, bus.iREN, bus.iaddr, bus.dp_ihit, wa);
        end
        step();
      end
      bus.flush = 1'b0;
      bus.iwait = 1'b1;
      bus.iload = $urandom;
      if (fl_fill) model_clear_valid();
      m_valid[idx] = 1'b1;
      m_addr[idx]  = wa;
      m_data[idx]  = d;
      @(negedge CLK);
      n_checks++;
      if (bus.dp_ihit !== 1'b1 || bus.dp_imemload !== d || bus.iREN !== 1'b0) begin
        n_errors++;
        $display("FAIL refill_hit addr=%h ihit=%b data=%h iren=%b want 1/%h/0",
                 addr, bus.dp_ihit, bus.dp_imemload, bus.iREN, d);
      end
      m_hits++;
      step();
    end
    bus.dp_imemREN = 1'b0;
  endtask

  task automatic do_flush_idle();
    bus.dp_imemREN = 1'b0;
    bus.flush      = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bus.dp_ihit !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ihit got=%b want=0", bus.dp_ihit);
    end
    model_clear_valid();
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    n_checks++;
    if (bus.hit_count !== 32'(m_hits) || bus.miss_count !== 32'(m_misses)) begin
      n_errors++;
      $display("FAIL stats hit=%0d miss=%0d want %0d/%0d",
               bus.hit_count, bus.miss_count, m_hits, m_misses);
    end
    step();
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 1'b0;
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = 32'h40;
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    model_clear_valid();
    m_hits = 0;
    m_misses = 0;
    #3;
    @(negedge CLK);
    n_checks++;
    if (bus.dp_ihit !== 1'b0 || bus.dp_imemload !== 32'h0 || bus.iREN !== 1'b0 ||
        bus.iaddr !== 32'h0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_outputs ihit=%b load=%h iren=%b iaddr=%h state=%0d want 0/0/0/0/IDLE",
               bus.dp_ihit, bus.dp_imemload, bus.iREN, bus.iaddr, dbg_state);
    end
    bus.dp_imemREN = 1'b0;
    nRST = 1'b1;
    step();
    test_stats();
  endtask

  task automatic test_cold_miss();
    mem[32'h40] = 32'h8C01_0004;
    do_read(32'h40, 3, 1'b0, 1'b0);
    do_read(32'h40, 0, 1'b0, 1'b0);
    do_read(32'h42, 0, 1'b0, 1'b0);
    test_stats();
  endtask

  task automatic test_conflict();
    do_read(32'h80, 1, 1'b0, 1'b0);
    do_read(32'h40, 2, 1'b0, 1'b0);
    do_read(32'h40, 0, 1'b0, 1'b0);
  endtask

  task automatic test_addr_change();
    word_t d;
    do_flush_idle();
    get_mem(32'h40, d);
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = 32'h40;
    bus.iwait       = 1'b1;
    m_misses++;
    step();
    bus.dp_imemaddr = 32'h100;
    for (int k = 0; k <= 2; k++) begin
      bus.iwait = (k < 2);
      bus.iload = (k < 2) ? $urandom : d;
      if (k == 2) bus.dp_imemREN = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (bus.dp_ihit !== 1'b0 || bus.iaddr !== 32'h40 || bus.iREN !== 1'b1) begin
        n_errors++;
        $display("FAIL stale_fetch cyc=%0d ihit=%b iaddr=%h iren=%b want 0/00000040/1",
                 k, bus.dp_ihit, bus.iaddr, bus.iREN);
      end
      step();
    end
    bus.iwait = 1'b1;
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h40;
    m_data[0]  = d;
    do_read(32'h40, 0, 1'b0, 1'b0);
    do_read(32'h100, 1, 1'b0, 1'b0);
    test_stats();
  endtask

  task automatic test_flush();
    do_read(32'h40, 0, 1'b0, 1'b0);
    do_read(32'h44, 0, 1'b0, 1'b0);
    do_flush_idle();
    do_read(32'h40, 1, 1'b0, 1'b0);
    do_read(32'h40, 0, 1'b1, 1'b0);
    do_read(32'h44, 0, 1'b0, 1'b0);
    do_read(32'h200, 2, 1'b0, 1'b1);
    do_read(32'h44, 0, 1'b0, 1'b0);
    do_read(32'h200, 0, 1'b0, 1'b0);
    test_stats();
  endtask

  task automatic test_boundary();
    do_read(32'hFFFF_FFFC, 1, 1'b0, 1'b0);
    do_read(32'h0000_003C, 1, 1'b0, 1'b0);
    do_read(32'hFFFF_FFFC, 0, 1'b0, 1'b0);
    do_read(32'h0000_0000, 0, 1'b0, 1'b0);
    do_read(32'hFFFF_FFC0, 0, 1'b0, 1'b0);
    do_read(32'h0000_0000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    do_flush_idle();
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = 32'h40;
    bus.iwait       = 1'b1;
    step();
    step();
    #2;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0 || bus.dp_ihit !== 1'b0 ||
        bus.dp_imemload !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_fetch iren=%b iaddr=%h ihit=%b load=%h want 0/0/0/0",
               bus.iREN, bus.iaddr, bus.dp_ihit, bus.dp_imemload);
    end
    model_clear_valid();
    m_hits = 0;
    m_misses = 0;
    bus.dp_imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    test_stats();
    do_read(32'h40, 1, 1'b0, 1'b0);
    do_read(32'h40, 0, 1'b0, 1'b0);
    do_read(32'h40, 0, 1'b0, 1'b0);
    test_stats();
  endtask

  task automatic test_random();
    word_t a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'hFFFF_FFFC;
        1:       a = 32'hFFFF_FF00 | word_t'($urandom_range(0, 63) << 2);
        default: a = word_t'($urandom_range(0, 127) << 2) | word_t'($urandom_range(0, 3));
      endcase
      do_read(a, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0));
    end
    test_stats();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.dp_imemREN  = 1'b0;
    bus.dp_imemaddr = 32'h0;
    bus.flush       = 1'b0;
    bus.iwait       = 1'b1;
    bus.iload       = 32'h0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_addr_change();
    test_flush();
    test_boundary();
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout sim_time=%0t limit=500000", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
